// File: rtl/life_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// life_ctrl_pkg : shared state encoding and default sizing for life_controller
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package life_ctrl_pkg;

  localparam int c_DEF_GRID_W = 1024;
  localparam int c_DEF_CNT_W  = 16;
  localparam int c_DEF_DIV_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/life_tick_div.sv
// ---------------------------------------------------------------------------
// life_tick_div : evolve-rate divider, ticks once every period+1 enabled cycles
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module life_tick_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [DIV_W-1:0] i_period,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_count;

  assign o_tick = i_enable && (r_count == i_period);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + DIV_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/life_controller.sv
// ---------------------------------------------------------------------------
// life_controller : sequencing FSM for the Game-of-Life grid register
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module life_controller
  import life_ctrl_pkg::*;
#(
  parameter int GRID_W = c_DEF_GRID_W,
  parameter int CNT_W  = c_DEF_CNT_W,
  parameter int DIV_W  = c_DEF_DIV_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_step,
  input  logic [DIV_W-1:0]  i_period,
  input  logic [CNT_W-1:0]  i_max_gen,
  input  logic [GRID_W-1:0] i_grid_q,
  input  logic [GRID_W-1:0] i_grid_d,
  output logic              o_load_en,
  output logic              o_evolve_en,
  output logic [CNT_W-1:0]  o_gen_count,
  output logic              o_running,
  output logic              o_halted
);

  state_t           r_state;
  logic             r_step_pending;
  logic             r_step_d;
  logic [CNT_W-1:0] r_gen_count;
  logic             r_load_en;
  logic             r_running;
  logic             r_halted;

  logic             w_in_run;
  logic             w_tick;
  logic             w_go_run;
  logic             w_run_pt;
  logic             w_step_pt;
  logic             w_stable;
  logic             w_evolve_en;
  logic [CNT_W-1:0] w_gen_next;
  logic             w_limit;
  logic             w_step_rise;

  assign w_in_run = (r_state == ST_RUN);

  // Divider only counts in RUN and is held at zero elsewhere, so entering RUN starts fresh
  life_tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (!w_in_run),
    .i_enable (w_in_run),
    .i_period (i_period),
    .o_tick   (w_tick)
  );

  assign w_go_run    = i_start && !i_pause;
  assign w_run_pt    = w_in_run && w_tick && !i_load && !i_pause;
  assign w_step_pt   = (r_state == ST_PAUSE) && r_step_pending && !i_load && !w_go_run;
  assign w_stable    = (i_grid_d == i_grid_q);
  assign w_evolve_en = (w_run_pt || w_step_pt) && !w_stable;
  assign w_gen_next  = (r_gen_count == {CNT_W{1'b1}}) ? r_gen_count : r_gen_count + CNT_W'(1);
  assign w_limit     = (i_max_gen != '0) && (w_gen_next == i_max_gen);
  assign w_step_rise = i_step && !r_step_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_step_pending <= 1'b0;
      r_step_d       <= 1'b0;
      r_gen_count    <= '0;
      r_load_en      <= 1'b0;
      r_running      <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      r_step_d  <= i_step;
      r_load_en <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_state   <= ST_LOAD;
            r_load_en <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state        <= ST_PAUSE;
          r_gen_count    <= '0;
          r_step_pending <= 1'b0;
        end
        ST_PAUSE: begin
          if (i_load) begin
            r_state   <= ST_LOAD;
            r_load_en <= 1'b1;
          end else if (w_go_run) begin
            r_state        <= ST_RUN;
            r_running      <= 1'b1;
            r_step_pending <= 1'b0;
          end else if (w_step_pt) begin
            r_step_pending <= 1'b0;
            if (w_stable || w_limit) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end
            if (!w_stable) begin
              r_gen_count <= w_gen_next;
            end
          end else if (w_step_rise && !r_step_pending) begin
            r_step_pending <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_load) begin
            r_state   <= ST_LOAD;
            r_load_en <= 1'b1;
          end else if ((w_run_pt && w_stable) || (w_evolve_en && w_limit)) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
            if (w_evolve_en) begin
              r_gen_count <= w_gen_next;
            end
          end else begin
            if (w_evolve_en) begin
              r_gen_count <= w_gen_next;
            end
            if (i_pause || !i_start) begin
              r_state <= ST_PAUSE;
            end else begin
              r_running <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (i_load) begin
            r_state   <= ST_LOAD;
            r_load_en <= 1'b1;
          end else begin
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_load_en   = r_load_en;
  assign o_evolve_en = w_evolve_en;
  assign o_gen_count = r_gen_count;
  assign o_running   = r_running;
  assign o_halted    = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_life_controller.sv
// ---------------------------------------------------------------------------
// tb_life_controller : directed self-checking bench for life_controller
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_life_controller;

  localparam int GRID_W = 16;
  localparam int CNT_W  = 8;
  localparam int DIV_W  = 4;

  logic              clk;
  logic              reset;
  logic              r_load, r_start, r_pause, r_step;
  logic [DIV_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_max_gen;
  logic [GRID_W-1:0] r_grid_q, r_grid_d;
  logic              w_load_en, w_evolve_en, w_running, w_halted;
  logic [CNT_W-1:0]  w_gen_count;

  int n_checks;
  int n_fail;
  int n_evolve;

  life_controller #(
    .GRID_W (GRID_W),
    .CNT_W  (CNT_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_load      (r_load),
    .i_start     (r_start),
    .i_pause     (r_pause),
    .i_step      (r_step),
    .i_period    (r_period),
    .i_max_gen   (r_max_gen),
    .i_grid_q    (r_grid_q),
    .i_grid_d    (r_grid_d),
    .o_load_en   (w_load_en),
    .o_evolve_en (w_evolve_en),
    .o_gen_count (w_gen_count),
    .o_running   (w_running),
    .o_halted    (w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    r_load   = 1'b0;
    r_start  = 1'b0;
    r_pause  = 1'b0;
    r_step   = 1'b0;
    r_period = '0;
    r_max_gen = '0;
    r_grid_q = 16'hA5A5;
    r_grid_d = 16'h5A5A;

    // Reset state
    repeat (3) clk_step();
    check("rst_load_en", 32'(w_load_en), 0);
    check("rst_evolve",  32'(w_evolve_en), 0);
    check("rst_gen",     32'(w_gen_count), 0);
    check("rst_running", 32'(w_running), 0);
    check("rst_halted",  32'(w_halted), 0);
    reset = 1'b0;

    // IDLE ignores start/step; load pulse -> LOAD then PAUSE
    r_start = 1'b1;
    r_step  = 1'b1;
    clk_step();
    check("idle_running", 32'(w_running), 0);
    r_start = 1'b0;
    r_step  = 1'b0;
    clk_step();
    r_load = 1'b1;
    clk_step();
    r_load = 1'b0;
    #1;
    check("load_en_hi",   32'(w_load_en), 1);
    check("load_evolve",  32'(w_evolve_en), 0);
    check("load_gen",     32'(w_gen_count), 0);
    clk_step();
    check("pause_load_en", 32'(w_load_en), 0);
    check("pause_running", 32'(w_running), 0);
    check("pause_halted",  32'(w_halted), 0);

    // period=3, start held: PAUSE cycle then 20 RUN cycles, evolve every 4th
    r_period = 4'd3;
    r_start  = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      #1;
      check($sformatf("run_evolve_%0d", i), 32'(w_evolve_en), ((i > 0) && (i % 4 == 0)) ? 1 : 0);
      clk_step();
    end
    check("run_running", 32'(w_running), 1);
    check("run_gen5",    32'(w_gen_count), 5);
    r_start = 1'b0;
    #1;
    check("stop_evolve", 32'(w_evolve_en), 0);
    clk_step();
    check("stop_running", 32'(w_running), 0);
    check("stop_gen5",    32'(w_gen_count), 5);

    // Step held 10 cycles in PAUSE -> exactly one evolve
    r_step   = 1'b1;
    n_evolve = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (w_evolve_en) n_evolve++;
      clk_step();
    end
    r_step = 1'b0;
    check("step_count", 32'(n_evolve), 1);
    check("step_gen6",  32'(w_gen_count), 6);
    clk_step();

    // max_gen=4, period=0: four consecutive evolves then HALT
    r_load = 1'b1;
    clk_step();
    r_load = 1'b0;
    clk_step();
    check("lim_gen0", 32'(w_gen_count), 0);
    r_max_gen = 8'd4;
    r_period  = 4'd0;
    r_start   = 1'b1;
    n_evolve  = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("lim_evolve_%0d", i), 32'(w_evolve_en), ((i >= 1) && (i <= 4)) ? 1 : 0);
      if (w_evolve_en) n_evolve++;
      clk_step();
    end
    check("lim_count",  32'(n_evolve), 4);
    check("lim_halted", 32'(w_halted), 1);
    check("lim_gen4",   32'(w_gen_count), 4);
    r_step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("halt_evolve_%0d", i), 32'(w_evolve_en), 0);
      clk_step();
    end
    r_step = 1'b0;
    check("halt_still",  32'(w_halted), 1);
    check("halt_gen4",   32'(w_gen_count), 4);

    // Stable grid during RUN -> no evolve, HALT; load recovers
    r_start   = 1'b0;
    r_max_gen = '0;
    r_load = 1'b1;
    clk_step();
    r_load = 1'b0;
    clk_step();
    r_grid_d = r_grid_q;
    r_start  = 1'b1;
    clk_step();
    check("stab_running", 32'(w_running), 1);
    check("stab_evolve",  32'(w_evolve_en), 0);
    clk_step();
    check("stab_halted",  32'(w_halted), 1);
    check("stab_gen0",    32'(w_gen_count), 0);
    r_load = 1'b1;
    clk_step();
    r_load = 1'b0;
    #1;
    check("reload_en",     32'(w_load_en), 1);
    check("reload_halted", 32'(w_halted), 0);
    check("reload_gen",    32'(w_gen_count), 0);
    clk_step();

    // pause+load together in RUN -> LOAD wins, no evolve
    r_grid_d = 16'h0F0F;
    clk_step();
    check("pl_evolve_pre", 32'(w_evolve_en), 1);
    r_pause = 1'b1;
    r_load  = 1'b1;
    #1;
    check("pl_evolve", 32'(w_evolve_en), 0);
    check("pl_load_en_pre", 32'(w_load_en), 0);
    clk_step();
    r_pause = 1'b0;
    r_load  = 1'b0;
    #1;
    check("pl_load_en", 32'(w_load_en), 1);
    check("pl_evolve2", 32'(w_evolve_en), 0);
    check("pl_gen0",    32'(w_gen_count), 0);
    clk_step();
    clk_step();
    clk_step();
    check("mid_running", 32'(w_running), 1);
    check("mid_evolve",  32'(w_evolve_en), 1);
    check("mid_gen1",    32'(w_gen_count), 1);

    // Asynchronous reset mid-RUN
    reset = 1'b1;
    #1;
    check("arst_evolve",  32'(w_evolve_en), 0);
    check("arst_load_en", 32'(w_load_en), 0);
    check("arst_running", 32'(w_running), 0);
    check("arst_halted",  32'(w_halted), 0);
    check("arst_gen",     32'(w_gen_count), 0);
    r_start = 1'b0;
    clk_step();
    reset = 1'b0;
    clk_step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/life_controller.md
LIFE_CONTROLLER -- requirements
Module: life_controller

Interface
REQ-001 Parameter GRID_W, default 1024: number of cells in the flattened grid.
REQ-002 Parameter CNT_W, default 16: width of the generation counter and max_gen.
REQ-003 Parameter DIV_W, default 8: width of the evolve-rate divider.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset; asynchronous, active-high.
REQ-006 load  input  1  level; request to load the seed into the grid register.
REQ-007 start  input  1  level; request continuous evolution.
REQ-008 pause  input  1  level; request to stop evolution.
REQ-009 step  input  1  level; request a single evolution while paused.
REQ-010 period  input  DIV_W  evolve once every period+1 cycles while running.
REQ-011 max_gen  input  CNT_W  generation limit; 0 means unlimited.
REQ-012 grid_q  input  GRID_W  current grid, from the grid register.
REQ-013 grid_d  input  GRID_W  next grid, from the evolve datapath.
REQ-014 load_en  output  1  selects the seed into the grid register this cycle.
REQ-015 evolve_en  output  1  grid register captures grid_d this cycle.
REQ-016 gen_count  output  CNT_W  generations evolved since the last load.
REQ-017 running  output  1  high in RUN.
REQ-018 halted  output  1  high in HALT.

Function
REQ-019 FSM states: IDLE, LOAD, PAUSE, RUN, HALT; outputs are decoded from registered state, divider and step_pending only.
REQ-020 Input priority each cycle: load > pause > start > step.
REQ-021 IDLE: load -> LOAD; start, pause and step are ignored.
REQ-022 LOAD lasts exactly 1 cycle: load_en=1, gen_count<=0, divider<=0, step_pending<=0; then PAUSE.
REQ-023 PAUSE: start -> RUN with divider<=0; step with step_pending=0 sets step_pending; load -> LOAD.
REQ-024 step_pending=1 in PAUSE produces exactly one evolve_en cycle on the next cycle, then clears; a held step produces one evolve per rising edge of step.
REQ-025 RUN: divider increments each cycle; at divider==period, evolve_en=1 for that cycle and divider<=0.
REQ-026 period=0 gives evolve_en on every RUN cycle.
REQ-027 RUN with pause=1 -> PAUSE; evolve_en is forced 0 in that cycle.
REQ-028 RUN with start=0 -> PAUSE.
REQ-029 Each evolve_en cycle increments gen_count; gen_count saturates at 2^CNT_W-1.
REQ-030 Stability: at an evolve point (RUN or step), if grid_d==grid_q, evolve_en is suppressed and the state goes to HALT.
REQ-031 Limit: if max_gen!=0 and an evolve makes gen_count==max_gen, the evolve occurs and the state goes to HALT.
REQ-032 HALT: halted=1; only load is accepted (-> LOAD); start and step are ignored.
REQ-033 load_en and evolve_en are never high in the same cycle.

Reset
REQ-034 Reset forces IDLE, divider=0, step_pending=0, gen_count=0, and load_en=evolve_en=running=halted=0.
REQ-035 Reset asserted mid-RUN takes effect immediately, with no further evolve_en.

Structure
REQ-036 Package life_ctrl_pkg holds the state enum typedef and the default parameter constants.
REQ-037 The divider is a sub-module life_tick_div (inputs clear, enable, period; output tick).

Verification
REQ-038 reset; load pulse -> load_en=1 for 1 cycle, gen_count=0, state PAUSE.
REQ-039 period=3, start held with a non-stable grid for 20 cycles -> evolve_en on every 4th cycle, gen_count=5.
REQ-040 In PAUSE, step held 10 cycles -> exactly 1 evolve_en, gen_count+1.
REQ-041 max_gen=4, period=0, start -> 4 consecutive evolves, then halted=1; a further start gives no evolve.
REQ-042 grid_d==grid_q during RUN -> no evolve_en, halted=1; load -> LOAD, gen_count=0.
REQ-043 pause and load together in RUN -> LOAD wins and evolve_en=0; reset mid-RUN -> all outputs 0 in the same cycle.
